// File: rtl/seg_pkg.sv
// Shared constants and FSM state type for the scanned seven-segment decoder.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

    localparam logic [6:0] SEG_DIGIT_0 = 7'h40;
    localparam logic [6:0] SEG_DIGIT_1 = 7'h79;
    localparam logic [6:0] SEG_DIGIT_2 = 7'h24;
    localparam logic [6:0] SEG_DIGIT_3 = 7'h30;
    localparam logic [6:0] SEG_DIGIT_4 = 7'h19;
    localparam logic [6:0] SEG_DIGIT_5 = 7'h12;
    localparam logic [6:0] SEG_DIGIT_6 = 7'h02;
    localparam logic [6:0] SEG_DIGIT_7 = 7'h78;
    localparam logic [6:0] SEG_DIGIT_8 = 7'h00;
    localparam logic [6:0] SEG_DIGIT_9 = 7'h10;
    localparam logic [6:0] SEG_BLANK   = 7'h7F;

    localparam logic [3:0] NIBBLE_INVALID = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HELD
    } scan_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational decode of one active-low segment pattern to a BCD value.
// A blank digit reports value 0 with the blank flag set.
module seg_pattern_decode
    import seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       blank,
    output logic       invalid
);

    always_comb begin
        value   = NIBBLE_INVALID;
        blank   = 1'b0;
        invalid = 1'b0;
        case (seg)
            SEG_DIGIT_0: value = 4'd0;
            SEG_DIGIT_1: value = 4'd1;
            SEG_DIGIT_2: value = 4'd2;
            SEG_DIGIT_3: value = 4'd3;
            SEG_DIGIT_4: value = 4'd4;
            SEG_DIGIT_5: value = 4'd5;
            SEG_DIGIT_6: value = 4'd6;
            SEG_DIGIT_7: value = 4'd7;
            SEG_DIGIT_8: value = 4'd8;
            SEG_DIGIT_9: value = 4'd9;
            SEG_BLANK: begin
                value = 4'd0;
                blank = 1'b1;
            end
            default: invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers the four displayed digits from a multiplexed seven-segment scan,
// capturing each digit once it has been stable and publishing whole frames.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  seg_in,
    input  logic [3:0]  an_in,
    output logic [15:0] digit_val,
    output logic [3:0]  digit_blank,
    output logic        frame_valid,
    output logic        frame_err
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    scan_state_t state, state_next;
    logic [10:0]   cand, cand_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          capture;
    logic          start_new;

    logic [10:0] sample;
    logic        single;
    logic [1:0]  cap_idx;

    logic [3:0]  dec_value;
    logic        dec_blank;
    logic        dec_invalid;

    logic [15:0] shadow_val;
    logic [3:0]  shadow_blank;
    logic [3:0]  shadow_err;
    logic [3:0]  seen_mask;
    logic [3:0]  seen_next;
    logic [3:0]  err_next;
    logic        publish;

    assign sample  = {an_in, seg_in};
    assign single  = $onehot(~an_in);
    assign publish = (seen_mask == 4'hF);

    seg_pattern_decode u_decode (
        .seg     (seg_in),
        .value   (dec_value),
        .blank   (dec_blank),
        .invalid (dec_invalid)
    );

    always_comb begin
        cap_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!an_in[i]) cap_idx = 2'(i);
        end
    end

    // A new candidate either starts settling or, with a one-sample threshold, is captured at once.
    always_comb begin
        state_next = state;
        cand_next  = cand;
        cnt_next   = cnt;
        capture    = 1'b0;
        start_new  = 1'b0;
        case (state)
            IDLE: begin
                if (single) start_new = 1'b1;
                else        cnt_next  = '0;
            end
            SETTLE: begin
                if (!single) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (sample == cand) begin
                    if (cnt + 1'b1 >= CNT_MAX) begin
                        cnt_next   = CNT_MAX;
                        capture    = 1'b1;
                        state_next = HELD;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end else begin
                    start_new = 1'b1;
                end
            end
            HELD: begin
                if (!single) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (sample != cand) begin
                    start_new = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        if (start_new) begin
            cand_next = sample;
            if (CNT_MAX == CNT_ONE) begin
                cnt_next   = CNT_MAX;
                capture    = 1'b1;
                state_next = HELD;
            end else begin
                cnt_next   = CNT_ONE;
                state_next = SETTLE;
            end
        end
    end

    // Publishing clears the mask first so a same-cycle capture starts the next frame.
    always_comb begin
        seen_next = publish ? 4'h0 : seen_mask;
        err_next  = publish ? 4'h0 : shadow_err;
        if (capture) begin
            seen_next[cap_idx] = 1'b1;
            err_next[cap_idx]  = dec_invalid;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            cand         <= '0;
            cnt          <= '0;
            shadow_val   <= '0;
            shadow_blank <= '0;
            shadow_err   <= '0;
            seen_mask    <= '0;
            digit_val    <= 16'h0000;
            digit_blank  <= 4'hF;
            frame_valid  <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            state       <= state_next;
            cand        <= cand_next;
            cnt         <= cnt_next;
            seen_mask   <= seen_next;
            shadow_err  <= err_next;
            frame_valid <= publish;
            frame_err   <= publish && (|shadow_err);
            if (capture) begin
                shadow_val[cap_idx*4 +: 4] <= dec_value;
                shadow_blank[cap_idx]      <= dec_blank;
            end
            if (publish) begin
                digit_val   <= shadow_val;
                digit_blank <= shadow_blank;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed scan sequences; expected frames go into a scoreboard queue and a
// monitor compares each published frame, including its publish cycle.
module tb_seg_scan_decoder;

    localparam int STABLE = 4;

    logic        clk;
    logic        reset_n;
    logic [6:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] digit_val;
    logic [3:0]  digit_blank;
    logic        frame_valid;
    logic        frame_err;

    typedef struct {
        logic [15:0] val;
        logic [3:0]  blank;
        logic        err;
        int          cyc;
    } frame_t;

    frame_t expQ[$];
    int     cyc;
    int     nTotal;
    int     nPass;

    seg_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .seg_in      (seg_in),
        .an_in       (an_in),
        .digit_val   (digit_val),
        .digit_blank (digit_blank),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nTotal++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Drives one sample per cycle at the falling edge; reports the cycle of the first drive.
    task automatic applyStimulus(input logic [3:0] an, input logic [6:0] seg, input int n, output int firstCyc);
        firstCyc = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (k == 0) firstCyc = cyc;
            an_in  = an;
            seg_in = seg;
        end
    endtask

    task automatic scanDigit(input int idx, input logic [6:0] seg, input int n, output int firstCyc);
        logic [3:0] an;
        an      = 4'b1111;
        an[idx] = 1'b0;
        applyStimulus(an, seg, n, firstCyc);
    endtask

    task automatic idleCycles(input int n);
        int dummy;
        applyStimulus(4'b1111, 7'h7F, n, dummy);
    endtask

    task automatic expectFrame(input logic [15:0] val, input logic [3:0] blank, input logic err, input int captureStart);
        frame_t f;
        f.val   = val;
        f.blank = blank;
        f.err   = err;
        f.cyc   = captureStart + STABLE + 1;
        expQ.push_back(f);
    endtask

    task automatic scanFrame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2, input logic [6:0] s3,
                             input logic [15:0] val, input logic [3:0] blank, input logic err);
        int c0;
        scanDigit(0, s0, STABLE, c0);
        scanDigit(1, s1, STABLE, c0);
        scanDigit(2, s2, STABLE, c0);
        scanDigit(3, s3, STABLE, c0);
        expectFrame(val, blank, err, c0);
    endtask

    always @(negedge clk) begin
        if (reset_n && frame_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_frame", 32'(digit_val), 32'hFFFF_FFFF);
            end else begin
                frame_t f;
                f = expQ.pop_front();
                checkOutput("digit_val",   32'(digit_val),   32'(f.val));
                checkOutput("digit_blank", 32'(digit_blank), 32'(f.blank));
                checkOutput("frame_err",   32'(frame_err),   32'(f.err));
                checkOutput("publish_cycle", 32'(cyc),       32'(f.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        cyc     = 0;
        nTotal  = 0;
        nPass   = 0;
        reset_n = 1'b0;
        an_in   = 4'b1111;
        seg_in  = 7'h7F;
        repeat (3) @(negedge clk);
        checkOutput("reset_digit_val",   32'(digit_val),   32'h0000);
        checkOutput("reset_digit_blank", 32'(digit_blank), 32'hF);
        checkOutput("reset_frame_valid", 32'(frame_valid), 32'h0);
        checkOutput("reset_frame_err",   32'(frame_err),   32'h0);
        reset_n = 1'b1;
        idleCycles(2);

        $display("[TB] plain scan 1,2,3,4");
        scanFrame(7'h79, 7'h24, 7'h30, 7'h19, 16'h4321, 4'b0000, 1'b0);
        idleCycles(3);

        $display("[TB] invalid pattern on digit 2");
        scanFrame(7'h79, 7'h24, 7'h55, 7'h19, 16'h4F21, 4'b0000, 1'b1);
        idleCycles(3);

        $display("[TB] digit 1 too short, rescanned later");
        scanDigit(0, 7'h12, STABLE, c0);
        scanDigit(1, 7'h02, STABLE - 1, c0);
        scanDigit(2, 7'h78, STABLE, c0);
        scanDigit(3, 7'h00, STABLE, c0);
        idleCycles(3);
        scanDigit(1, 7'h02, STABLE, c0);
        expectFrame(16'h8765, 4'b0000, 1'b0, c0);
        idleCycles(3);

        $display("[TB] two anodes low treated as idle");
        scanDigit(0, 7'h10, STABLE, c0);
        scanDigit(1, 7'h40, 2, c0);
        applyStimulus(4'b1100, 7'h40, 10, c0);
        scanDigit(1, 7'h40, STABLE, c0);
        scanDigit(2, 7'h79, STABLE, c0);
        scanDigit(3, 7'h24, STABLE, c0);
        expectFrame(16'h2109, 4'b0000, 1'b0, c0);
        idleCycles(3);

        $display("[TB] reset after partial frame");
        scanDigit(0, 7'h79, STABLE, c0);
        scanDigit(1, 7'h24, STABLE, c0);
        scanDigit(2, 7'h30, STABLE, c0);
        @(negedge clk);
        reset_n = 1'b0;
        an_in   = 4'b1111;
        seg_in  = 7'h7F;
        repeat (2) @(negedge clk);
        checkOutput("midreset_digit_val",   32'(digit_val),   32'h0000);
        checkOutput("midreset_digit_blank", 32'(digit_blank), 32'hF);
        reset_n = 1'b1;
        idleCycles(2);
        scanFrame(7'h10, 7'h10, 7'h10, 7'h7F, 16'h0999, 4'b1000, 1'b0);
        idleCycles(3);

        $display("[TB] continuous scan of 8s for three frames");
        for (int f = 0; f < 3; f++) begin
            scanFrame(7'h00, 7'h00, 7'h00, 7'h00, 16'h8888, 4'b0000, 1'b0);
        end
        idleCycles(6);

        checkOutput("pending_frames", 32'(expQ.size()), 32'h0);
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, is the number of consecutive identical samples required before a digit is captured; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 seg_in  input  7  active-low segment lines {g,f,e,d,c,b,a} from a scanned 4-digit display.
REQ-005 an_in  input  4  active-low digit anodes; an_in[i]=0 selects digit i.
REQ-006 digit_val  output  16  decoded frame, nibble i = digit i, values 0..9.
REQ-007 digit_blank  output  4  bit i set = digit i was blank (seg_in=7'h7F) in the last frame.
REQ-008 frame_valid  output  1  one-cycle pulse when digit_val/digit_blank update.
REQ-009 frame_err  output  1  one-cycle pulse coincident with frame_valid if any digit in that frame held an undecodable pattern.

Function
REQ-010 Decode table (seg_in hex -> value) SHALL be 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 7F->blank; any other pattern is invalid, decodes to nibble 4'hF and sets that digit's error flag.
REQ-011 A sample is "single" when exactly one bit of an_in is 0; any other an_in (none or several low) is "idle".
REQ-012 FSM states SHALL be IDLE, SETTLE, HELD.
REQ-013 IDLE: on a single sample, latch {an_in, seg_in} as candidate, load stability counter with 1, go to SETTLE (or directly capture if STABLE_CYCLES=1).
REQ-014 SETTLE: if {an_in, seg_in} equals candidate, increment counter; on reaching STABLE_CYCLES, capture and go to HELD; on a different single sample, restart with new candidate (counter=1); on idle sample, go to IDLE.
REQ-015 HELD: remain while {an_in, seg_in} equals candidate (no recapture); on different single sample restart SETTLE with it; on idle go to IDLE.
REQ-016 Capture SHALL write decoded nibble, blank flag and error flag into per-digit shadow registers and set that digit's bit in a 4-bit seen-mask; recapture of an already-seen digit before frame completion overwrites its shadow entry.
REQ-017 When the seen-mask becomes 4'hF, on the next cycle digit_val and digit_blank SHALL load from shadow, frame_valid pulses, frame_err pulses iff any shadow error flag set, and seen-mask and error flags clear.
REQ-018 Latency: frame_valid asserts exactly 1 cycle after the capture cycle that completed the mask; a capture occurring in that same publish cycle is applied to the new (cleared) mask.
REQ-019 digit_val and digit_blank SHALL hold their values between frames.
REQ-020 Stability counter SHALL saturate at STABLE_CYCLES; width = clog2(STABLE_CYCLES+1).

Reset
REQ-021 While reset_n=0 at a clock edge: state=IDLE, counter=0, seen-mask=0, shadow and error flags=0, digit_val=16'h0000, digit_blank=4'hF, frame_valid=0, frame_err=0.
REQ-022 Reset mid-frame SHALL discard partial captures; no frame_valid follows until four fresh captures complete.

Structure
REQ-023 Package seg_pkg SHALL hold the ten digit pattern constants, the blank pattern 7'h7F, the invalid nibble 4'hF and the FSM state enum.
REQ-024 Pattern decoding SHALL live in one combinational sub-module seg_pattern_decode (seg[6:0] -> value[3:0], blank, invalid); all other logic in seg_scan_decoder.

Verification
REQ-025 Scan digits 0..3 showing 1,2,3,4 for 4 cycles each (STABLE_CYCLES=4) -> one frame_valid, digit_val=16'h4321, digit_blank=0, frame_err=0.
REQ-026 Same scan but digit 2 holds seg_in=7'h55 -> digit_val nibble 2=4'hF, frame_err=1 with frame_valid.
REQ-027 Digit 1 shown 3 cycles then anode moves -> no capture for digit 1, no frame_valid until digit 1 later held 4 cycles.
REQ-028 an_in=4'b1100 for 10 cycles inside a scan -> treated as idle, no capture, counter restarts afterwards.
REQ-029 Assert reset_n=0 after digits 0..2 captured, then scan 9,9,9,7F -> single frame, digit_val nibbles 0..2=9, digit_blank=4'b1000.
REQ-030 Continuous scan of 8,8,8,8 for 3 frames -> frame_valid pulses once per frame, exactly 1 cycle after each digit-3 capture.
